// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative 32-bit multiply/divide unit owning HI/LO
module mult_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        mthi,
  input  logic        mtlo,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t      state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic        is_div_q, is_div_d;
  logic [31:0] opnd_q, opnd_d;
  logic [31:0] acc_hi_q, acc_hi_d;
  logic [31:0] acc_lo_q, acc_lo_d;
  logic [31:0] dvd_q, dvd_d;
  logic        neg_q, neg_d;
  logic        rs_neg_q, rs_neg_d;
  logic        dz_q, dz_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        signed_op, rs_neg, rt_neg;
  logic [31:0] rs_abs, rt_abs;
  logic [32:0] mul_sum;
  logic [32:0] div_shift, div_trial;
  logic [63:0] prod, prod_fix;
  logic [31:0] quo_fix, rem_fix;

  assign signed_op = ~op[0];
  assign rs_neg    = signed_op & rs_val[31];
  assign rt_neg    = signed_op & rt_val[31];
  assign rs_abs    = rs_neg ? (32'd0 - rs_val) : rs_val;
  assign rt_abs    = rt_neg ? (32'd0 - rt_val) : rt_val;

  // 33-bit sum keeps the carry that shifts into the accumulator MSB
  assign mul_sum   = {1'b0, acc_hi_q} + {1'b0, opnd_q};
  assign div_shift = {acc_hi_q, acc_lo_q[31]};
  assign div_trial = div_shift - {1'b0, opnd_q};

  assign prod      = {acc_hi_q, acc_lo_q};
  assign prod_fix  = neg_q ? (64'd0 - prod) : prod;
  assign quo_fix   = neg_q ? (32'd0 - acc_lo_q) : acc_lo_q;
  assign rem_fix   = rs_neg_q ? (32'd0 - acc_hi_q) : acc_hi_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      count_q  <= 5'd0;
      is_div_q <= 1'b0;
      opnd_q   <= 32'd0;
      acc_hi_q <= 32'd0;
      acc_lo_q <= 32'd0;
      dvd_q    <= 32'd0;
      neg_q    <= 1'b0;
      rs_neg_q <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      is_div_q <= is_div_d;
      opnd_q   <= opnd_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      dvd_q    <= dvd_d;
      neg_q    <= neg_d;
      rs_neg_q <= rs_neg_d;
      dz_q     <= dz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (count_q == 5'd31) state_d = S_FIX;
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_d = (state_d != S_IDLE);
    done_d = (state_q == S_FIX);
  end

  always_comb begin
    count_d  = count_q;
    is_div_d = is_div_q;
    opnd_d   = opnd_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    dvd_d    = dvd_q;
    neg_d    = neg_q;
    rs_neg_d = rs_neg_q;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          // opnd holds the multiplicand or the divisor; acc_lo the other operand
          count_d  = 5'd0;
          is_div_d = op[1];
          opnd_d   = op[1] ? rt_abs : rs_abs;
          acc_hi_d = 32'd0;
          acc_lo_d = op[1] ? rs_abs : rt_abs;
          dvd_d    = rs_val;
          neg_d    = rs_neg ^ rt_neg;
          rs_neg_d = rs_neg;
          dz_d     = (rt_val == 32'd0);
        end else begin
          if (mthi) hi_d = rs_val;
          if (mtlo) lo_d = rs_val;
        end
      end
      S_RUN: begin
        count_d = count_q + 5'd1;
        if (is_div_q) begin
          if (!div_trial[32]) begin
            acc_hi_d = div_trial[31:0];
            acc_lo_d = {acc_lo_q[30:0], 1'b1};
          end else begin
            acc_hi_d = div_shift[31:0];
            acc_lo_d = {acc_lo_q[30:0], 1'b0};
          end
        end else if (acc_lo_q[0]) begin
          acc_hi_d = mul_sum[32:1];
          acc_lo_d = {mul_sum[0], acc_lo_q[31:1]};
        end else begin
          acc_hi_d = {1'b0, acc_hi_q[31:1]};
          acc_lo_d = {acc_hi_q[0], acc_lo_q[31:1]};
        end
      end
      S_FIX: begin
        if (!is_div_q) begin
          hi_d = prod_fix[63:32];
          lo_d = prod_fix[31:0];
        end else if (dz_q) begin
          hi_d = dvd_q;
          lo_d = 32'hFFFF_FFFF;
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
      end
      default: ;
    endcase
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
